// File: rtl/spi_boot_loader_pkg.sv
// Shared definitions for the SPI boot loader: FSM state encoding, command
// bytes, error codes and the sticky-error update rule.
// Optional checksum stage is compiled in with SPI_LOADER_CSUM_EN.
package spi_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_H,
    ST_CNT_L,
    ST_ADR_H,
    ST_ADR_L,
    ST_DATA,
`ifdef SPI_LOADER_CSUM_EN
    ST_WRITE,
    ST_CSUM
`else
    ST_WRITE
`endif
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;
  localparam logic [7:0] CMD_HALT = 8'h3C;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CMD  = 2'b01;
  localparam logic [1:0] ERR_OVR  = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

  // First error is kept until cleared; a new error in the clear cycle wins.
  function automatic logic [1:0] err_merge(input logic [1:0] cur,
                                           input logic [1:0] new_err,
                                           input logic       clr);
    if (new_err != ERR_NONE && (cur == ERR_NONE || clr)) return new_err;
    else if (clr)                                        return ERR_NONE;
    else                                                 return cur;
  endfunction

endpackage

// File: rtl/spi_word_pack.sv
// Assembles four bytes (MSB first) into a 32-bit word. o_done strobes with
// the fourth byte; the full word is visible on o_word the following cycle.
module spi_word_pack (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // Shift register and byte index; clear only rewinds the index so the
  // last assembled word stays stable on the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
    end else if (i_vld) begin
      r_word <= {r_word[23:0], i_byte};
      r_idx  <= r_idx + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_done = i_vld && !i_clr && (r_idx == 2'd3);

endmodule

// File: rtl/spi_boot_loader.sv
// SPI boot loader command sequencer: decodes LOAD/RUN/HALT, writes loaded
// words into instruction memory and controls the core reset.
// Define SPI_LOADER_CSUM_EN to add the trailing frame checksum byte.
module spi_boot_loader
  import spi_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_vld,
  input  logic              i_mem_rdy,
  input  logic              i_err_clr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic [1:0]        o_err
);

`ifdef SPI_LOADER_CSUM_EN
  localparam state_t ST_FRAME_END = ST_CSUM;
`else
  localparam state_t ST_FRAME_END = ST_IDLE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_cnt;
  logic [7:0]        r_adr_hi;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cpu_rst_n;
  logic              r_ovr;
  logic [1:0]        r_err;
  logic [1:0]        w_err_set;
  logic              w_pack_vld;
  logic              w_pack_clr;
  logic              w_done;
  logic [31:0]       w_word;
`ifdef SPI_LOADER_CSUM_EN
  logic [7:0]        r_sum;
  logic [7:0]        w_sum_chk;
  assign w_sum_chk = r_sum + i_byte;
`endif

  assign w_pack_vld = i_byte_vld && (r_state == ST_DATA);
  assign w_pack_clr = (r_state == ST_IDLE);

  spi_word_pack u_pack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_pack_clr),
    .i_vld   (w_pack_vld),
    .i_byte  (i_byte),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and error detection.
  always_comb begin
    w_next    = r_state;
    w_err_set = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_byte_vld) begin
          if (i_byte == CMD_LOAD)
            w_next = ST_CNT_H;
          else if (i_byte != CMD_RUN && i_byte != CMD_HALT)
            w_err_set = ERR_CMD;
        end
      end
      ST_CNT_H: if (i_byte_vld) w_next = ST_CNT_L;
      ST_CNT_L: if (i_byte_vld) w_next = ST_ADR_H;
      ST_ADR_H: if (i_byte_vld) w_next = ST_ADR_L;
      ST_ADR_L: begin
        if (i_byte_vld) w_next = (r_cnt != 16'd0) ? ST_DATA : ST_FRAME_END;
      end
      ST_DATA: if (w_done) w_next = ST_WRITE;
      ST_WRITE: begin
        if (i_byte_vld) w_err_set = ERR_OVR;
        // An overrun seen at any point during the write abandons the frame
        // once the pending write has been accepted.
        if (i_mem_rdy) begin
          if (r_ovr || i_byte_vld)  w_next = ST_IDLE;
          else if (r_cnt == 16'd1)  w_next = ST_FRAME_END;
          else                      w_next = ST_DATA;
        end
      end
`ifdef SPI_LOADER_CSUM_EN
      ST_CSUM: begin
        if (i_byte_vld) begin
          if (w_sum_chk != 8'd0) w_err_set = ERR_CSUM;
          w_next = ST_IDLE;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame counters, address, core reset control and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_adr_hi    <= '0;
      r_addr      <= '0;
      r_cpu_rst_n <= ~HOLD_ON_RESET;
      r_ovr       <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_err <= err_merge(r_err, w_err_set, i_err_clr);
      case (r_state)
        ST_IDLE: begin
          if (i_byte_vld) begin
            if (i_byte == CMD_LOAD || i_byte == CMD_HALT) r_cpu_rst_n <= 1'b0;
            else if (i_byte == CMD_RUN)                   r_cpu_rst_n <= 1'b1;
          end
        end
        ST_CNT_H: if (i_byte_vld) r_cnt[15:8] <= i_byte;
        ST_CNT_L: if (i_byte_vld) r_cnt[7:0]  <= i_byte;
        ST_ADR_H: if (i_byte_vld) r_adr_hi    <= i_byte;
        ST_ADR_L: if (i_byte_vld) r_addr      <= ADDR_W'({r_adr_hi, i_byte});
        ST_WRITE: begin
          if (i_byte_vld) r_ovr <= 1'b1;
          if (i_mem_rdy) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - 16'd1;
            r_ovr  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_LOADER_CSUM_EN
  // Running sum of every frame byte after the LOAD command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_byte_vld) begin
      if (r_state == ST_IDLE)
        r_sum <= '0;
      else if (r_state == ST_CNT_H || r_state == ST_CNT_L ||
               r_state == ST_ADR_H || r_state == ST_ADR_L ||
               r_state == ST_DATA)
        r_sum <= r_sum + i_byte;
    end
  end
`endif

  assign o_mem_we    = (r_state == ST_WRITE);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = w_word;
  assign o_cpu_rst_n = r_cpu_rst_n;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;

endmodule
